// File: rtl/contador_param_if.sv
// Bus bundle for contador_param: control/data inputs and registered counter outputs.
// There is no valid/ready pair: the counter samples enable/cin/mode/D on every rising edge
// and its outputs Q/rco/load/ovf are valid from just after that edge until the next one.
interface contador_param_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             cin;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             rco;
  logic             load;
  logic             ovf;

  modport master (
    output enable, cin, mode, D,
    input  Q, rco, load, ovf
  );

  modport slave (
    input  enable, cin, mode, D,
    output Q, rco, load, ovf
  );
endinterface

// File: rtl/contador_param.sv
// Parametrised cascadable counter: up by STEP / down by 1 / up by 1 / load, with
// wrap-or-clamp policy, registered ripple-carry and load strobes and a sticky overflow flag.
module contador_param #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      STEP     = 3,
  parameter logic [WIDTH-1:0] MAX      = '1,
  parameter bit               SATURATE = 1'b0
) (
  input logic              clk,
  input logic              reset,
  contador_param_if.slave  bus
);

  localparam logic [1:0] MODE_UP_STEP = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b01;
  localparam logic [1:0] MODE_UP_ONE  = 2'b10;
  localparam logic [1:0] MODE_LOAD    = 2'b11;

  localparam logic [WIDTH:0]   MAX_X  = {1'b0, MAX};
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   ONE_X  = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  logic [WIDTH-1:0] q_r,    q_nxt;
  logic             rco_r,  rco_nxt;
  logic             load_r, load_nxt;
  logic             ovf_r,  ovf_nxt;
  logic [WIDTH:0]   inc;
  logic [WIDTH:0]   sum;

  always_comb begin
    q_nxt    = q_r;
    rco_nxt  = 1'b0;
    load_nxt = 1'b0;
    ovf_nxt  = ovf_r;
    inc      = (bus.mode == MODE_UP_STEP) ? STEP_X : ONE_X;
    sum      = {1'b0, q_r} + inc;

    if (bus.enable) begin
      if (bus.mode == MODE_LOAD) begin
        q_nxt    = (bus.D > MAX) ? MAX : bus.D;
        load_nxt = 1'b1;
        ovf_nxt  = 1'b0;
      end else if (bus.cin) begin
        case (bus.mode)
          MODE_UP_STEP, MODE_UP_ONE: begin
            // Sum is one bit wider so a crossing past MAX is never lost to truncation.
            if (sum > MAX_X) begin
              rco_nxt = 1'b1;
              q_nxt   = SATURATE ? MAX : WIDTH'(sum - MAX_X - ONE_X);
            end else begin
              q_nxt = WIDTH'(sum);
            end
          end
          MODE_DOWN: begin
            if (q_r != '0) begin
              q_nxt = q_r - ONE_W;
            end else begin
              rco_nxt = 1'b1;
              q_nxt   = SATURATE ? '0 : MAX;
            end
          end
          default: q_nxt = q_r;
        endcase
        ovf_nxt = ovf_r | rco_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r    <= '0;
      rco_r  <= 1'b0;
      load_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      rco_r  <= rco_nxt;
      load_r <= load_nxt;
      ovf_r  <= ovf_nxt;
    end
  end

  assign bus.Q    = q_r;
  assign bus.rco  = rco_r;
  assign bus.load = load_r;
  assign bus.ovf  = ovf_r;

endmodule
